tri_state_bus_reader: RTL and testbench
=======================================

Name: tri_state_bus_reader

Overview:
Receive-side endpoint of the shared 8-bit tri-state data bus. It never drives the bus. It samples the bus on every clock in which the bus owner's enable is high and buffers the samples in a small first-word-fall-through FIFO with a valid/ready read port. It also checks sample continuity against the driver's free-running, increment-by-one counter and reports drops and sequence errors. It sits alongside each bus driver as the consumer and self-check of bus traffic.

Parameters:
DEPTH, 4, FIFO entries; power of two, range 2..16.
CNT_W, 16, width of the sample counter.

Ports:
i_clk  input  1  system clock; all sampling on the rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_bus_en  input  1  bus-owner drive enable; high means the bus carries valid data this cycle.
i_bus_data  input  8  bus value (the resolved io_data net); input only.
i_clear  input  1  synchronous clear of FIFO, counters, sticky flags and checker state.
o_rd_data  output  8  FIFO head data; valid only when o_rd_valid=1.
o_rd_valid  output  1  FIFO not empty.
i_rd_ready  input  1  consumer accepts the head this cycle.
o_full  output  1  FIFO holds DEPTH entries.
o_overflow  output  1  sticky; a sample was dropped because the FIFO was full.
o_seq_err  output  1  sticky; at least one sequence mismatch occurred.
o_err_count  output  8  count of sequence mismatches; saturates at 255.
o_sample_count  output  CNT_W  count of all bus samples, including dropped ones; wraps modulo 2^CNT_W.

Behaviour:
- Reset (i_rst_n=0, asynchronous): FIFO empty, o_rd_valid=0, o_full=0, o_rd_data=0, o_overflow=0, o_seq_err=0, o_err_count=0, o_sample_count=0, checker state IDLE, expected=0.
- Sample event: a rising edge with i_bus_en=1 and i_clear=0. i_bus_data is captured directly, with no synchronizer, because the driver shares i_clk.
- Each sample event increments o_sample_count.
- Push: the sample is written to the FIFO if it is not full, or if it is full and a pop happens in the same cycle.
- Drop: if the FIFO is full and no pop happens, the sample is discarded and o_overflow is set.
- Latency: a sample captured at edge N is visible at the FIFO head (o_rd_valid=1) after edge N, provided the FIFO was empty.
- Pop: when o_rd_valid=1 and i_rd_ready=1 at a rising edge. i_rd_ready while empty has no effect.
- Simultaneous push and pop with the FIFO empty: not possible; the push takes effect and the pop is ignored.
- Simultaneous push and pop otherwise: both take effect and occupancy is unchanged.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. o_full and o_rd_valid are derived from the pointer compare.
- Checker FSM, state IDLE: on a sample event, load expected=sample+1 and go to TRACK. No error is raised.
- Checker FSM, state TRACK: expected increments by 1 (mod 256) every clock, whether or not the bus is enabled. This mirrors the driver's free-running counter, so enable gaps do not cause errors.
- TRACK with a sample event: compare sample to expected.
  - Match: expected = sample+1.
  - Mismatch: set o_seq_err, increment o_err_count (saturating at 255), then resync with expected = sample+1.
- Wrap-around: 0xFF followed by 0x00 is a match.
- i_clear=1 (synchronous, highest priority after reset): FIFO is flushed, all counters and sticky flags are zeroed, and the FSM returns to IDLE. A sample or pop in the same cycle is ignored.
- Reset asserted mid-transfer: all state is lost immediately. The first sample after release is treated as an IDLE resync.
- All outputs are registered, or derived combinationally only from registered pointers and the FIFO array.

Test Plan:
- Driver START_VALUE=0x10, enable held high for 4 cycles, i_rd_ready=1 -> read stream 0x10,0x11,0x12,0x13; o_sample_count=4; o_seq_err=0; o_err_count=0.
- Enable for 2 cycles (0x10,0x11), low for 3 cycles, high for 1 cycle -> third sample is 0x15 and is accepted with no error; o_sample_count=3.
- Force i_bus_data=0x40 where 0x22 is expected, then 0x41 -> o_seq_err=1 and o_err_count=1. The following 0x41 matches with no further error, confirming resync.
- i_rd_ready=0, 6 consecutive samples 0x00..0x05, DEPTH=4 -> o_full=1, o_overflow=1, o_sample_count=6; draining yields 0x00..0x03 only.
- Continuous enable across the 0xFE,0xFF,0x00,0x01 wrap -> no error. Separately, 300 forced mismatches -> o_err_count stays at 255.
- Mid-stream, pulse i_rst_n low asynchronously (between edges), then separately pulse i_clear with a concurrent sample -> reset drives all outputs to 0 immediately. The clear empties the FIFO and drops the concurrent sample. The first sample after each enters TRACK without an error.

Source files
------------

// File: rtl/tri_state_bus_reader.sv
// tri_state_bus_reader: samples the shared bus into a FWFT FIFO and checks
// sample continuity against the driver's free-running counter.
module tri_state_bus_reader #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bus_en,
    input  logic [7:0]       i_bus_data,
    input  logic             i_clear,
    output logic [7:0]       o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic             o_full,
    output logic             o_overflow,
    output logic             o_seq_err,
    output logic [7:0]       o_err_count,
    output logic [CNT_W-1:0] o_sample_count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, TRACK} state_t;
    state_t state, state_nx;
    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0] exp_q, exp_nx, err_nx;
    logic seq_nx, sample, pop, push, drop;
    assign o_rd_valid = wr_ptr != rd_ptr;
    assign o_full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign o_rd_data = o_rd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
    assign sample = i_bus_en & ~i_clear;
    assign pop = o_rd_valid & i_rd_ready & ~i_clear;
    // a full FIFO still accepts a sample when the head leaves in the same cycle
    assign push = sample & (~o_full | pop);
    assign drop = sample & o_full & ~pop;
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= i_bus_data;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_overflow     <= 1'b0;
            o_sample_count <= '0;
        end else if (i_clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_overflow     <= 1'b0;
            o_sample_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop) o_overflow <= 1'b1;
            if (sample) o_sample_count <= o_sample_count + CNT_W'(1);
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            exp_q       <= 8'h00;
            o_seq_err   <= 1'b0;
            o_err_count <= 8'h00;
        end else begin
            state       <= state_nx;
            exp_q       <= exp_nx;
            o_seq_err   <= seq_nx;
            o_err_count <= err_nx;
        end
    end
    // expected advances every clock in TRACK so enable gaps stay in step with the driver
    always_comb begin
        state_nx = state;
        exp_nx   = exp_q;
        seq_nx   = o_seq_err;
        err_nx   = o_err_count;
        if (i_clear) begin
            state_nx = IDLE;
            exp_nx   = 8'h00;
            seq_nx   = 1'b0;
            err_nx   = 8'h00;
        end else if (state == IDLE) begin
            state_nx = sample ? TRACK : IDLE;
            exp_nx   = sample ? i_bus_data + 8'd1 : exp_q;
        end else begin
            exp_nx = sample ? i_bus_data + 8'd1 : exp_q + 8'd1;
            if (sample && i_bus_data != exp_q) begin
                seq_nx = 1'b1;
                err_nx = o_err_count + {7'd0, o_err_count != 8'hFF};
            end
        end
    end
endmodule

// File: tb/tb_tri_state_bus_reader.sv
// tb_tri_state_bus_reader: directed scenarios for the bus reader with
// hand-computed expectations.
module tb_tri_state_bus_reader;
    logic i_clk = 1'b0;
    logic i_rst_n, i_bus_en, i_clear, i_rd_ready;
    logic [7:0] i_bus_data, o_rd_data, o_err_count;
    logic o_rd_valid, o_full, o_overflow, o_seq_err;
    logic [15:0] o_sample_count;
    int errors = 0;
    int checks = 0;

    tri_state_bus_reader #(.DEPTH(4), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bus_en(i_bus_en), .i_bus_data(i_bus_data),
        .i_clear(i_clear), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .i_rd_ready(i_rd_ready), .o_full(o_full), .o_overflow(o_overflow),
        .o_seq_err(o_seq_err), .o_err_count(o_err_count), .o_sample_count(o_sample_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_clear();
        i_bus_en = 1'b0;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic drive(input logic [7:0] d);
        i_bus_en = 1'b1;
        i_bus_data = d;
        tick();
        i_bus_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({o_rd_valid, o_full, o_overflow, o_seq_err} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=0000", {o_rd_valid, o_full, o_overflow, o_seq_err});
        end
        checks++;
        if ({o_rd_data, o_err_count, o_sample_count} !== 32'h0) begin
            errors++; $display("FAIL reset_values got=%h want=00000000", {o_rd_data, o_err_count, o_sample_count});
        end
    endtask

    task automatic test_stream();
        do_clear();
        i_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(8'h10 + 8'(i));
            checks++;
            if (!o_rd_valid || o_rd_data !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL stream_head[%0d] got=%h/%b want=%h/1", i, o_rd_data, o_rd_valid, 8'h10 + 8'(i));
            end
        end
        tick();
        checks++;
        if (o_rd_valid !== 1'b0 || o_sample_count !== 16'd4 || o_seq_err !== 1'b0 || o_err_count !== 8'd0) begin
            errors++; $display("FAIL stream_end got valid=%b cnt=%0d seq=%b err=%0d want 0/4/0/0", o_rd_valid, o_sample_count, o_seq_err, o_err_count);
        end
    endtask

    task automatic test_gap();
        do_clear();
        drive(8'h10);
        drive(8'h11);
        repeat (3) tick();
        drive(8'h15);
        checks++;
        if (o_seq_err !== 1'b0 || o_err_count !== 8'd0 || o_sample_count !== 16'd3 || o_rd_data !== 8'h15) begin
            errors++; $display("FAIL gap got seq=%b err=%0d cnt=%0d head=%h want 0/0/3/15", o_seq_err, o_err_count, o_sample_count, o_rd_data);
        end
    endtask

    task automatic test_mismatch();
        do_clear();
        drive(8'h20);
        drive(8'h21);
        drive(8'h40);
        checks++;
        if (o_seq_err !== 1'b1 || o_err_count !== 8'd1) begin
            errors++; $display("FAIL mismatch got seq=%b err=%0d want 1/1", o_seq_err, o_err_count);
        end
        drive(8'h41);
        checks++;
        if (o_err_count !== 8'd1) begin
            errors++; $display("FAIL resync got err=%0d want 1", o_err_count);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        i_rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive(8'(i));
        checks++;
        if (o_full !== 1'b1 || o_overflow !== 1'b1 || o_sample_count !== 16'd6) begin
            errors++; $display("FAIL overflow got full=%b ovf=%b cnt=%0d want 1/1/6", o_full, o_overflow, o_sample_count);
        end
        i_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!o_rd_valid || o_rd_data !== 8'(i)) begin
                errors++; $display("FAIL drain[%0d] got=%h/%b want=%h/1", i, o_rd_data, o_rd_valid, 8'(i));
            end
            tick();
        end
        checks++;
        if (o_rd_valid !== 1'b0 || o_full !== 1'b0) begin
            errors++; $display("FAIL drain_empty got valid=%b full=%b want 0/0", o_rd_valid, o_full);
        end
    endtask

    task automatic test_wrap();
        do_clear();
        i_rd_ready = 1'b1;
        drive(8'hFE);
        drive(8'hFF);
        drive(8'h00);
        drive(8'h01);
        checks++;
        if (o_seq_err !== 1'b0 || o_err_count !== 8'd0) begin
            errors++; $display("FAIL wrap got seq=%b err=%0d want 0/0", o_seq_err, o_err_count);
        end
        do_clear();
        for (int i = 0; i < 301; i++) drive(8'h00);
        checks++;
        if (o_err_count !== 8'd255 || o_seq_err !== 1'b1 || o_sample_count !== 16'd301) begin
            errors++; $display("FAIL saturate got err=%0d seq=%b cnt=%0d want 255/1/301", o_err_count, o_seq_err, o_sample_count);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        i_rd_ready = 1'b0;
        drive(8'h30);
        drive(8'h99);
        #2;
        i_rst_n = 1'b0;
        #1;
        test_reset();
        #1;
        i_rst_n = 1'b1;
        i_rd_ready = 1'b1;
        drive(8'h50);
        drive(8'h51);
        checks++;
        if (o_seq_err !== 1'b0 || o_sample_count !== 16'd2 || o_rd_data !== 8'h51) begin
            errors++; $display("FAIL post_reset got seq=%b cnt=%0d head=%h want 0/2/51", o_seq_err, o_sample_count, o_rd_data);
        end
    endtask

    task automatic test_clear();
        i_rd_ready = 1'b0;
        drive(8'h60);
        drive(8'h61);
        i_clear = 1'b1;
        i_bus_en = 1'b1;
        i_bus_data = 8'h62;
        tick();
        i_clear = 1'b0;
        i_bus_en = 1'b0;
        checks++;
        if (o_rd_valid !== 1'b0 || o_sample_count !== 16'd0 || o_overflow !== 1'b0) begin
            errors++; $display("FAIL clear got valid=%b cnt=%0d ovf=%b want 0/0/0", o_rd_valid, o_sample_count, o_overflow);
        end
        drive(8'h90);
        drive(8'h91);
        checks++;
        if (o_seq_err !== 1'b0 || o_rd_data !== 8'h90 || o_sample_count !== 16'd2) begin
            errors++; $display("FAIL post_clear got seq=%b head=%h cnt=%0d want 0/90/2", o_seq_err, o_rd_data, o_sample_count);
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_bus_en = 1'b0;
        i_bus_data = 8'h00;
        i_clear = 1'b0;
        i_rd_ready = 1'b0;
        repeat (2) tick();
        test_reset();
        i_rst_n = 1'b1;
        tick();
        test_stream();
        test_gap();
        test_mismatch();
        test_overflow();
        test_wrap();
        test_async_reset();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
